// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and memory.
// master : load/store unit (drives request, address, write enable, strobes, write data)
// slave  : memory side (drives grant, response valid, read data)
//   bus_req    request, held until granted
//   bus_addr   word-aligned byte address
//   bus_we     1 = store, 0 = load
//   bus_wstrb  byte strobes (0 for loads)
//   bus_wdata  lane-replicated store data
//   bus_gnt    request accepted
//   bus_rvalid load data / store ack
//   bus_rdata  load data, valid with bus_rvalid
interface lsu_if;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_addr, bus_we, bus_wstrb, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_addr, bus_we, bus_wstrb, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit. Accepts one memory instruction from execute, runs a
// request/grant/response transaction on the data bus, and returns an
// extended load result or a store completion to writeback. The pipeline is
// stalled while the transaction is in flight.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   lsu_i_valid     memory instruction present
//   lsu_i_addr      byte address
//   lsu_i_wdata     store data (low bits used per size)
//   lsu_i_we        1 = store, 0 = load
//   lsu_i_size      00 byte, 01 half, 10 word, 11 illegal
//   lsu_i_unsigned  zero-extend loads
//   lsu_o_ready     idle, can accept
//   lsu_o_stall     hold PC and upstream registers
//   lsu_o_done      one-cycle completion pulse
//   lsu_o_err       one-cycle error pulse (with done)
//   lsu_o_rdata     extended load data, valid with done
//   bus             data-memory bus (master side)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready; accepts a new instruction
// REQ   | bus_req held high until grant or timeout
// WAIT  | granted, waiting for rvalid or timeout
// RESP  | done pulse with registered result
// ERR   | done + err pulse, rdata = 0 (misaligned or timeout)
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_i_valid,
   input  logic [31:0] lsu_i_addr,
   input  logic [31:0] lsu_i_wdata,
   input  logic        lsu_i_we,
   input  logic [1:0]  lsu_i_size,
   input  logic        lsu_i_unsigned,
   output logic        lsu_o_ready,
   output logic        lsu_o_stall,
   output logic        lsu_o_done,
   output logic        lsu_o_err,
   output logic [31:0] lsu_o_rdata,
   lsu_if.master       bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] REQ  = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] RESP = 3'd3;
   localparam logic [2:0] ERR  = 3'd4;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // A zero TIMEOUT_CYCLES disables the timeout; the compare value is then unused.
   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [15:0] to_cnt;
   logic [31:0] addr_q;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [3:0]  strb_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic        misaligned;
   logic [3:0]  strb_n;
   logic [31:0] wdata_n;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ext_rdata;
   logic        timeout;

   always_comb begin
      misaligned = 1'b0;
      case (lsu_i_size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = lsu_i_addr[0];
         SZ_W:    misaligned = (lsu_i_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Store lane build: data is replicated across lanes so memory can pick
   // the bytes it needs using only the strobes.
   always_comb begin
      wdata_n = lsu_i_wdata;
      strb_n  = 4'b0000;
      case (lsu_i_size)
         SZ_B: begin
            wdata_n = {4{lsu_i_wdata[7:0]}};
            strb_n  = 4'b0001 << lsu_i_addr[1:0];
         end
         SZ_H: begin
            wdata_n = {2{lsu_i_wdata[15:0]}};
            strb_n  = lsu_i_addr[1] ? 4'b1100 : 4'b0011;
         end
         SZ_W:    strb_n = 4'b1111;
         default: strb_n = 4'b0000;
      endcase
      if (!lsu_i_we) begin
         strb_n = 4'b0000;
      end
   end

   // Load lane select and extension from the latched access attributes.
   always_comb begin
      lane_b    = 8'h00;
      lane_h    = 16'h0000;
      ext_rdata = 32'h0000_0000;
      case (addr_q[1:0])
         2'd0:    lane_b = bus.bus_rdata[7:0];
         2'd1:    lane_b = bus.bus_rdata[15:8];
         2'd2:    lane_b = bus.bus_rdata[23:16];
         default: lane_b = bus.bus_rdata[31:24];
      endcase
      lane_h = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (size_q)
         SZ_B:    ext_rdata = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         SZ_H:    ext_rdata = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: ext_rdata = bus.bus_rdata;
      endcase
      if (we_q) begin
         ext_rdata = 32'h0000_0000;
      end
   end

   // The counter spans REQ and WAIT together; a gnt/rvalid in the final
   // cycle still wins over the timeout.
   always_comb begin
      timeout = 1'b0;
      if (TO_EN && (to_cnt == TO_LAST)) begin
         timeout = ((state == REQ) && !bus.bus_gnt) ||
                   ((state == WAIT) && !bus.bus_rvalid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         to_cnt  <= 16'h0000;
         addr_q  <= 32'h0000_0000;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         strb_q  <= 4'b0000;
         wdata_q <= 32'h0000_0000;
         rdata_q <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (lsu_i_valid) begin
                  addr_q  <= lsu_i_addr;
                  we_q    <= lsu_i_we;
                  size_q  <= lsu_i_size;
                  uns_q   <= lsu_i_unsigned;
                  strb_q  <= strb_n;
                  wdata_q <= wdata_n;
                  to_cnt  <= 16'h0000;
                  rdata_q <= 32'h0000_0000;
                  state   <= misaligned ? ERR : REQ;
               end
            end
            REQ: begin
               to_cnt <= to_cnt + 16'd1;
               if (bus.bus_gnt) begin
                  state <= WAIT;
               end else if (timeout) begin
                  state <= ERR;
               end
            end
            WAIT: begin
               to_cnt <= to_cnt + 16'd1;
               if (bus.bus_rvalid) begin
                  rdata_q <= ext_rdata;
                  state   <= RESP;
               end else if (timeout) begin
                  state <= ERR;
               end
            end
            RESP:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign lsu_o_ready = (state == IDLE);
   assign lsu_o_stall = (state == REQ) || (state == WAIT) ||
                        ((state == IDLE) && lsu_i_valid);
   assign lsu_o_done  = (state == RESP) || (state == ERR);
   assign lsu_o_err   = (state == ERR);
   // rdata_q is cleared at accept and only loaded on rvalid, so it reads 0 in ERR.
   assign lsu_o_rdata = rdata_q;

   assign bus.bus_req   = (state == REQ);
   assign bus.bus_addr  = {addr_q[31:2], 2'b00};
   assign bus.bus_we    = we_q;
   assign bus.bus_wstrb = strb_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu with a 4-cycle timeout.
module tb_lsu;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic        ready;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   lsu_if bus_if ();

   lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .lsu_i_valid    (valid),
      .lsu_i_addr     (addr),
      .lsu_i_wdata    (wdata),
      .lsu_i_we       (we),
      .lsu_i_size     (size),
      .lsu_i_unsigned (uns),
      .lsu_o_ready    (ready),
      .lsu_o_stall    (stall),
      .lsu_o_done     (done),
      .lsu_o_err      (err),
      .lsu_o_rdata    (rdata),
      .bus            (bus_if)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Shift-and-mask reference for load extension.
   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] sz, input logic u);
      logic [31:0] s;
      s = w >> (8 * a);
      if (sz == 2'b00) return u ? (s & 32'hFF) : ((s & 32'h80) != 0 ? (s | 32'hFFFF_FF00) : (s & 32'hFF));
      if (sz == 2'b01) return u ? (s & 32'hFFFF) : ((s & 32'h8000) != 0 ? (s | 32'hFFFF_0000) : (s & 32'hFFFF));
      return w;
   endfunction

   // gd/rd: grant/rvalid delay in cycles, negative = never.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [1:0] sz, input logic u,
                         input int gd, input int rd, input logic [31:0] word,
                         input logic exp_err, input int exp_lat,
                         input logic [3:0] exp_strb, input logic [31:0] exp_bwd);
      exp_t e;
      exp_t got;
      int   cyc;
      int   req_cnt;
      int   wait_cnt;
      int   stall_cnt;
      int   exp_req;
      bit   fin;
      e.err   = exp_err;
      e.rdata = (exp_err || w) ? 32'h0 : model_load(word, a[1:0], sz, u);
      sb_q.push_back(e);
      valid = 1'b1; addr = a; wdata = wd; we = w; size = sz; uns = u;
      #1;
      check_val({nm, ":accept_ready"}, ready, 1);
      check_val({nm, ":accept_stall"}, stall, 1);
      @(posedge clk); #1;
      valid = 1'b0;
      cyc = 0; req_cnt = 0; wait_cnt = 0; stall_cnt = 1; fin = 0;
      while (!fin && cyc < 40) begin
         cyc++;
         bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
         if (done) begin
            fin = 1;
            if (sb_q.size() == 0) begin
               check_val({nm, ":sb_underflow"}, 1, 0);
            end else begin
               got = sb_q.pop_front();
               check_val({nm, ":rdata"}, rdata, got.rdata);
               check_val({nm, ":err"}, err, got.err);
            end
            check_val({nm, ":latency"}, cyc, exp_lat);
            check_val({nm, ":done_stall"}, stall, 0);
            check_val({nm, ":done_req"}, bus_if.bus_req, 0);
         end else if (bus_if.bus_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
               check_val({nm, ":bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
               check_val({nm, ":bus_we"}, bus_if.bus_we, w);
               check_val({nm, ":bus_strb"}, bus_if.bus_wstrb, exp_strb);
               if (w) check_val({nm, ":bus_wdata"}, bus_if.bus_wdata, exp_bwd);
            end
            if (gd >= 0 && req_cnt > gd) bus_if.bus_gnt = 1'b1;
         end else begin
            wait_cnt++;
            if (rd >= 0 && wait_cnt > rd) begin
               bus_if.bus_rvalid = 1'b1;
               bus_if.bus_rdata  = word;
            end
         end
         if (stall) stall_cnt++;
         @(posedge clk); #1;
      end
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
      if (!fin) check_val({nm, ":done_bound"}, 0, 1);
      exp_req = (exp_lat == 1) ? 0 : ((gd < 0) ? TO : gd + 1);
      check_val({nm, ":req_cycles"}, req_cnt, exp_req);
      check_val({nm, ":stall_cycles"}, stall_cnt, exp_lat);
      check_val({nm, ":idle_ready"}, ready, 1);
   endtask

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      logic [31:0] rw;
      int          rg;
      int          rv;
      rst = 1'b1; valid = 1'b0; addr = 0; wdata = 0; we = 0; size = 0; uns = 0;
      bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", ready, 1);
      check_val("rst_stall", stall, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_req", bus_if.bus_req, 0);
      check_val("rst_we", bus_if.bus_we, 0);
      check_val("rst_addr", bus_if.bus_addr, 0);
      check_val("rst_strb", bus_if.bus_wstrb, 0);
      check_val("rst_wdata", bus_if.bus_wdata, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("lw",   32'h100, 0, 0, 2'b10, 0, 0, 0, 32'hDEADBEEF, 0, 3, 4'b0000, 0);
      run_op("lb3",  32'h103, 0, 0, 2'b00, 0, 0, 0, 32'h80FF7F01, 0, 3, 4'b0000, 0);
      run_op("lbu3", 32'h103, 0, 0, 2'b00, 1, 0, 0, 32'h80FF7F01, 0, 3, 4'b0000, 0);
      run_op("lh2",  32'h102, 0, 0, 2'b01, 0, 1, 0, 32'h80FF7F01, 0, 4, 4'b0000, 0);
      run_op("lb0",  32'h100, 0, 0, 2'b00, 0, 0, 1, 32'h80FF7F01, 0, 4, 4'b0000, 0);
      run_op("sb",   32'h203, 32'h000000AB, 1, 2'b00, 0, 0, 0, 32'h0, 0, 3, 4'b1000, 32'hABABABAB);
      run_op("sh",   32'h202, 32'h00001234, 1, 2'b01, 0, 1, 1, 32'h0, 0, 5, 4'b1100, 32'h12341234);
      run_op("sw",   32'h400, 32'h11223344, 1, 2'b10, 0, 0, 0, 32'h0, 0, 3, 4'b1111, 32'h11223344);
      run_op("mis_lw", 32'h102, 0, 0, 2'b10, 0, 0, 0, 32'h0, 1, 1, 4'b0000, 0);
      run_op("mis_lh", 32'h101, 0, 0, 2'b01, 0, 0, 0, 32'h0, 1, 1, 4'b0000, 0);
      run_op("mis_sz", 32'h100, 0, 0, 2'b11, 0, 0, 0, 32'h0, 1, 1, 4'b0000, 0);
      run_op("to_gnt", 32'h300, 0, 0, 2'b10, 0, -1, 0, 32'h0, 1, 5, 4'b0000, 0);
      run_op("gnt4",   32'h300, 0, 0, 2'b10, 0, 3, 0, 32'h55AA00FF, 0, 6, 4'b0000, 0);
      run_op("to_wait", 32'h304, 0, 0, 2'b10, 0, 0, -1, 32'h0, 1, 5, 4'b0000, 0);

      for (int i = 0; i < 16; i++) begin
         rsz = 2'($urandom_range(0, 2));
         ra  = $urandom;
         if (rsz == 2'b01) ra[0] = 1'b0;
         if (rsz == 2'b10) ra[1:0] = 2'b00;
         rw  = $urandom;
         rg  = $urandom_range(0, 1);
         rv  = $urandom_range(0, 1);
         run_op("rnd", ra, 0, 0, rsz, 1'($urandom_range(0, 1)), rg, rv, rw, 0, 3 + rg + rv,
                4'b0000, 0);
      end

      // Reset while waiting for rvalid, then a stray rvalid.
      valid = 1'b1; addr = 32'h500; we = 1'b0; size = 2'b10; uns = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0;
      check_val("rstw_req", bus_if.bus_req, 1);
      bus_if.bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_gnt = 1'b0;
      check_val("rstw_in_wait", bus_if.bus_req, 0);
      check_val("rstw_wait_stall", stall, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("rstw_ready", ready, 1);
      check_val("rstw_bus_req", bus_if.bus_req, 0);
      check_val("rstw_done", done, 0);
      bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_val("stray_done", done, 0);
         check_val("stray_ready", ready, 1);
         check_val("stray_req", bus_if.bus_req, 0);
      end
      bus_if.bus_rvalid = 1'b0;

      check_val("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
